// File: rtl/reg_scoreboard_ctrl_if.sv
// ID-stage scoreboard bus: issue, load-completion and retire events in; stall/hazard/tag out.
// The slave modport is the scoreboard; the master modport is the pipeline side driving it.
interface reg_scoreboard_ctrl_if #(
    parameter int NREG  = 32,
    parameter int SEQ_W = 2
);
    logic             flush_i;
    logic [4:0]       src1_addr_i;
    logic             src1_used_i;
    logic [4:0]       src2_addr_i;
    logic             src2_used_i;
    logic             iss_valid_i;
    logic             iss_we_i;
    logic [4:0]       iss_dest_i;
    logic             iss_is_load_i;
    logic [SEQ_W-1:0] iss_seq_o;
    logic             ld_done_i;
    logic [4:0]       ld_done_dest_i;
    logic [SEQ_W-1:0] ld_done_seq_i;
    logic             ret_valid_i;
    logic             ret_we_i;
    logic [4:0]       ret_dest_i;
    logic             hz_src1_o;
    logic             hz_src2_o;
    logic             id_ready_go_o;
    logic [NREG-1:0]  pend_mask_o;

    modport slave (
        input  flush_i,
        input  src1_addr_i, src1_used_i, src2_addr_i, src2_used_i,
        input  iss_valid_i, iss_we_i, iss_dest_i, iss_is_load_i,
        input  ld_done_i, ld_done_dest_i, ld_done_seq_i,
        input  ret_valid_i, ret_we_i, ret_dest_i,
        output iss_seq_o, hz_src1_o, hz_src2_o, id_ready_go_o, pend_mask_o
    );

    modport master (
        output flush_i,
        output src1_addr_i, src1_used_i, src2_addr_i, src2_used_i,
        output iss_valid_i, iss_we_i, iss_dest_i, iss_is_load_i,
        output ld_done_i, ld_done_dest_i, ld_done_seq_i,
        output ret_valid_i, ret_we_i, ret_dest_i,
        input  iss_seq_o, hz_src1_o, hz_src2_o, id_ready_go_o, pend_mask_o
    );
endinterface

// File: rtl/reg_scoreboard_ctrl.sv
// Register scoreboard / load-use interlock for the ID stage: counts in-flight GPR writers,
// tracks the youngest writer's tag and whether it is a load still waiting for its data.
module reg_scoreboard_ctrl #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2,
    parameter int SEQ_W = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    reg_scoreboard_ctrl_if.slave  sb_if
);
    localparam int AW = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q     [NREG];
    logic [CNT_W-1:0] cnt_d     [NREG];
    logic             ld_pend_q [NREG];
    logic             ld_pend_d [NREG];
    logic [SEQ_W-1:0] ysq_q     [NREG];
    logic [SEQ_W-1:0] ysq_d     [NREG];
    logic [SEQ_W-1:0] seq_ctr_q;
    logic [SEQ_W-1:0] seq_ctr_d;

    logic            iss_wr;
    logic            ret_wr;
    logic [NREG-1:0] iss_hit;
    logic [NREG-1:0] ret_hit;
    logic [NREG-1:0] ld_hit;
    logic            dest_full;
    logic            hz_src1;
    logic            hz_src2;
    logic            id_ready_go;

    assign iss_wr = sb_if.iss_valid_i & sb_if.iss_we_i & (sb_if.iss_dest_i != '0);
    assign ret_wr = sb_if.ret_valid_i & sb_if.ret_we_i & (sb_if.ret_dest_i != '0);

    always_comb begin
        iss_hit = '0;
        ret_hit = '0;
        ld_hit  = '0;
        for (int r = 1; r < NREG; r++) begin
            iss_hit[r] = iss_wr && (sb_if.iss_dest_i == AW'(r));
            ret_hit[r] = ret_wr && (sb_if.ret_dest_i == AW'(r));
            // Only the youngest writer's completion may clear the load flag.
            ld_hit[r]  = sb_if.ld_done_i && (sb_if.ld_done_dest_i == AW'(r))
                         && (ysq_q[r] == sb_if.ld_done_seq_i);
        end
    end

    always_comb begin
        seq_ctr_d = seq_ctr_q + SEQ_W'(sb_if.iss_valid_i);
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r]     = cnt_q[r];
            ld_pend_d[r] = ld_pend_q[r];
            ysq_d[r]     = ysq_q[r];
            if (iss_hit[r]) begin
                // Issue owns ysq/ld_pend; a same-cycle retire cancels the increment.
                ysq_d[r]     = seq_ctr_q;
                ld_pend_d[r] = sb_if.iss_is_load_i;
                if (!(ret_hit[r] && cnt_q[r] != '0) && cnt_q[r] != CNT_MAX) begin
                    cnt_d[r] = cnt_q[r] + CNT_W'(1);
                end
            end else if (ret_hit[r]) begin
                if (cnt_q[r] != '0) begin
                    cnt_d[r] = cnt_q[r] - CNT_W'(1);
                end
                if (ld_hit[r] || cnt_q[r] <= CNT_W'(1)) begin
                    ld_pend_d[r] = 1'b0;
                end
            end else if (ld_hit[r]) begin
                ld_pend_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || sb_if.flush_i) begin
            seq_ctr_q <= '0;
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r]     <= '0;
                ld_pend_q[r] <= 1'b0;
                ysq_q[r]     <= '0;
            end
        end else begin
            seq_ctr_q <= seq_ctr_d;
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r]     <= cnt_d[r];
                ld_pend_q[r] <= ld_pend_d[r];
                ysq_q[r]     <= ysq_d[r];
            end
        end
    end

    // No same-cycle ld_done bypass: the consumer picks the value up from WB a cycle later.
    assign hz_src1 = sb_if.src1_used_i && (sb_if.src1_addr_i != '0)
                     && (cnt_q[sb_if.src1_addr_i] != '0) && ld_pend_q[sb_if.src1_addr_i];
    assign hz_src2 = sb_if.src2_used_i && (sb_if.src2_addr_i != '0)
                     && (cnt_q[sb_if.src2_addr_i] != '0) && ld_pend_q[sb_if.src2_addr_i];

    assign dest_full = sb_if.iss_we_i && (sb_if.iss_dest_i != '0)
                       && (cnt_q[sb_if.iss_dest_i] == CNT_MAX)
                       && !(ret_wr && (sb_if.ret_dest_i == sb_if.iss_dest_i));

    assign id_ready_go = !hz_src1 && !hz_src2 && !dest_full;

    assign sb_if.hz_src1_o     = hz_src1;
    assign sb_if.hz_src2_o     = hz_src2;
    assign sb_if.id_ready_go_o = id_ready_go;
    assign sb_if.iss_seq_o     = seq_ctr_q;

    always_comb begin
        sb_if.pend_mask_o = '0;
        for (int r = 1; r < NREG; r++) begin
            sb_if.pend_mask_o[r] = (cnt_q[r] != '0);
        end
    end

    // Pipeline protocol checks: no retire of an idle register, no issue while stalled.
    always_ff @(posedge clk) begin
        if (resetn && !sb_if.flush_i) begin
            assert (!ret_wr || cnt_q[sb_if.ret_dest_i] != '0);
            assert (!sb_if.iss_valid_i || id_ready_go);
        end
    end
endmodule

// File: tb/tb_reg_scoreboard_ctrl.sv
// Directed bench for reg_scoreboard_ctrl: stimulus queues expected outputs, a negedge monitor
// pops one expectation per cycle and compares it with the DUT.
module tb_reg_scoreboard_ctrl;
    logic clk;
    logic resetn;

    reg_scoreboard_ctrl_if #(.NREG(32), .SEQ_W(2)) sb_if ();

    reg_scoreboard_ctrl #(.NREG(32), .CNT_W(2), .SEQ_W(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .sb_if  (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pm;
        logic [1:0]  sq;
        logic        h1;
        logic        h2;
        logic        rdy;
    } exp_t;

    exp_t  exp_q  [$];
    string name_q [$];
    int    checks = 0;
    int    errors = 0;

    function automatic void chk(string nm, string fld, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, got, want);
        end
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk(nm, "pend_mask",   sb_if.pend_mask_o,          e.pm);
            chk(nm, "iss_seq",     32'(sb_if.iss_seq_o),       32'(e.sq));
            chk(nm, "hz_src1",     32'(sb_if.hz_src1_o),       32'(e.h1));
            chk(nm, "hz_src2",     32'(sb_if.hz_src2_o),       32'(e.h2));
            chk(nm, "id_ready_go", 32'(sb_if.id_ready_go_o),   32'(e.rdy));
        end
    end

    task automatic clr();
        sb_if.flush_i        = 1'b0;
        sb_if.src1_addr_i    = '0;
        sb_if.src1_used_i    = 1'b0;
        sb_if.src2_addr_i    = '0;
        sb_if.src2_used_i    = 1'b0;
        sb_if.iss_valid_i    = 1'b0;
        sb_if.iss_we_i       = 1'b0;
        sb_if.iss_dest_i     = '0;
        sb_if.iss_is_load_i  = 1'b0;
        sb_if.ld_done_i      = 1'b0;
        sb_if.ld_done_dest_i = '0;
        sb_if.ld_done_seq_i  = '0;
        sb_if.ret_valid_i    = 1'b0;
        sb_if.ret_we_i       = 1'b0;
        sb_if.ret_dest_i     = '0;
    endtask

    // Queue the expected outputs for the inputs currently driven, then advance one cycle.
    task automatic cyc(string nm, logic [31:0] pm, logic [1:0] sq, logic h1, logic h2, logic rdy);
        exp_t e;
        e.pm = pm; e.sq = sq; e.h1 = h1; e.h2 = h2; e.rdy = rdy;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic iss(logic [4:0] d, logic ld);
        sb_if.iss_valid_i   = 1'b1;
        sb_if.iss_we_i      = 1'b1;
        sb_if.iss_dest_i    = d;
        sb_if.iss_is_load_i = ld;
    endtask

    task automatic ret(logic [4:0] d);
        sb_if.ret_valid_i = 1'b1;
        sb_if.ret_we_i    = 1'b1;
        sb_if.ret_dest_i  = d;
    endtask

    task automatic ldd(logic [4:0] d, logic [1:0] s);
        sb_if.ld_done_i      = 1'b1;
        sb_if.ld_done_dest_i = d;
        sb_if.ld_done_seq_i  = s;
    endtask

    task automatic s1(logic [4:0] a);
        sb_if.src1_used_i = 1'b1;
        sb_if.src1_addr_i = a;
    endtask

    task automatic s2(logic [4:0] a);
        sb_if.src2_used_i = 1'b1;
        sb_if.src2_addr_i = a;
    endtask

    initial begin
        resetn = 1'b0;
        clr();
        @(posedge clk);
        #1;
        s1(5'd5); s2(5'd7);
        cyc("reset", 32'h0, 2'd0, 1'b0, 1'b0, 1'b1);
        resetn = 1'b1;

        // load-use on r5
        iss(5'd5, 1'b1);               cyc("lu_issue",    32'h0,  2'd0, 0, 0, 1);
        s1(5'd5);                      cyc("lu_hazard",   32'h20, 2'd1, 1, 0, 0);
        s1(5'd5); ldd(5'd5, 2'd0);     cyc("lu_nobypass", 32'h20, 2'd1, 1, 0, 0);
        s1(5'd5);                      cyc("lu_cleared",  32'h20, 2'd1, 0, 0, 1);
        ret(5'd5);                     cyc("lu_retire",   32'h20, 2'd1, 0, 0, 1);
                                       cyc("lu_idle",     32'h0,  2'd1, 0, 0, 1);

        // younger non-load writer on r7
        iss(5'd7, 1'b1);               cyc("yw_ld",       32'h0,  2'd1, 0, 0, 1);
        s2(5'd7);                      cyc("yw_hazard",   32'h80, 2'd2, 0, 1, 0);
        iss(5'd7, 1'b0);               cyc("yw_add",      32'h80, 2'd2, 0, 0, 1);
        s2(5'd7); ldd(5'd7, 2'd1);     cyc("yw_nohz",     32'h80, 2'd3, 0, 0, 1);
        s2(5'd7); ret(5'd7);           cyc("yw_ret1",     32'h80, 2'd3, 0, 0, 1);
        ret(5'd7);                     cyc("yw_ret2",     32'h80, 2'd3, 0, 0, 1);
                                       cyc("yw_idle",     32'h0,  2'd3, 0, 0, 1);

        // stale tag on r9 (second load also shows tag wrap 3->0)
        iss(5'd9, 1'b1);               cyc("st_ld_a",     32'h0,   2'd3, 0, 0, 1);
        iss(5'd9, 1'b1);               cyc("st_ld_b",     32'h200, 2'd0, 0, 0, 1);
        s1(5'd9); ldd(5'd9, 2'd3);     cyc("st_stale",    32'h200, 2'd1, 1, 0, 0);
        s1(5'd9); ldd(5'd9, 2'd0);     cyc("st_still",    32'h200, 2'd1, 1, 0, 0);
        s1(5'd9);                      cyc("st_cleared",  32'h200, 2'd1, 0, 0, 1);
        ret(5'd9);                     cyc("st_ret1",     32'h200, 2'd1, 0, 0, 1);
        ret(5'd9);                     cyc("st_ret2",     32'h200, 2'd1, 0, 0, 1);
                                       cyc("st_idle",     32'h0,   2'd1, 0, 0, 1);

        // counter saturation on r4
        iss(5'd4, 1'b0);               cyc("sat_w1",      32'h0,  2'd1, 0, 0, 1);
        iss(5'd4, 1'b0);               cyc("sat_w2",      32'h10, 2'd2, 0, 0, 1);
        iss(5'd4, 1'b0);               cyc("sat_w3",      32'h10, 2'd3, 0, 0, 1);
        sb_if.iss_we_i = 1'b1; sb_if.iss_dest_i = 5'd4;
                                       cyc("sat_full",    32'h10, 2'd0, 0, 0, 0);
        iss(5'd4, 1'b0); ret(5'd4);    cyc("sat_iss_ret", 32'h10, 2'd0, 0, 0, 1);
        sb_if.iss_we_i = 1'b1; sb_if.iss_dest_i = 5'd4;
                                       cyc("sat_still",   32'h10, 2'd1, 0, 0, 0);
        ret(5'd4);                     cyc("sat_r1",      32'h10, 2'd1, 0, 0, 1);
        ret(5'd4);                     cyc("sat_r2",      32'h10, 2'd1, 0, 0, 1);
        ret(5'd4);                     cyc("sat_r3",      32'h10, 2'd1, 0, 0, 1);
                                       cyc("sat_idle",    32'h0,  2'd1, 0, 0, 1);

        // flush with loads pending and a same-cycle issue
        iss(5'd3, 1'b1);               cyc("fl_ld3",      32'h0,  2'd1, 0, 0, 1);
        iss(5'd6, 1'b1);               cyc("fl_ld6",      32'h8,  2'd2, 0, 0, 1);
        s1(5'd3); s2(5'd6);            cyc("fl_hz",       32'h48, 2'd3, 1, 1, 0);
        sb_if.flush_i = 1'b1; iss(5'd8, 1'b0);
                                       cyc("fl_flush",    32'h48, 2'd3, 0, 0, 1);
        s1(5'd3); s2(5'd6);            cyc("fl_after",    32'h0,  2'd0, 0, 0, 1);

        // r0 is never tracked
        iss(5'd0, 1'b1);               cyc("r0_issue",    32'h0,  2'd0, 0, 0, 1);
        s1(5'd0); s2(5'd0);            cyc("r0_read",     32'h0,  2'd1, 0, 0, 1);

        // non-writing issues still advance the tag, wrapping 3->0
        for (int i = 0; i < 4; i++) begin
            sb_if.iss_valid_i = 1'b1;
            cyc("wrap", 32'h0, 2'(i + 1), 0, 0, 1);
        end
                                       cyc("wrap_end",    32'h0,  2'd1, 0, 0, 1);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
